// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS systolic array: skewed operand feed, flush,
// row drain. Ports: clk_i/rst_i, start_i/k_len_i/mode_i/abort_i in; busy_o,
// done_o, mode_o, clr_o, feed_cnt_o, row_en_o, col_en_o, out_valid_o, out_row_o.
module systolic_seq_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K_WIDTH = 8,
  parameter int PE_LAT  = 2,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [K_WIDTH-1:0] k_len_i,
  input  logic [1:0]         mode_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         mode_o,
  output logic               clr_o,
  output logic [K_WIDTH:0]   feed_cnt_o,
  output logic [ROWS-1:0]    row_en_o,
  output logic [COLS-1:0]    col_en_o,
  output logic               out_valid_o,
  output logic [RW-1:0]      out_row_o
);

  localparam int CW   = K_WIDTH + 1;
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [1:0]         mode_q, mode_d;
  logic [CW-1:0]      last_feed;

  logic               busy_d, done_d, clr_d, ov_d;
  logic [CW-1:0]      fcnt_d, klen_d;
  logic [ROWS-1:0]    row_d;
  logic [COLS-1:0]    col_d;
  logic [RW-1:0]      orow_d;

  localparam logic [CW-1:0] FL_LAST = CW'(COLS + PE_LAT - 1);
  localparam logic [CW-1:0] DR_LAST = CW'(ROWS - 1);

  // Last feed index F-1 = K + MAXD - 2, done in the widened counter width.
  assign last_feed = {1'b0, k_q} + CW'(MAXD) - CW'(2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          state_d = S_FEED;
          cnt_d   = '0;
          k_d     = k_len_i;
          mode_d  = mode_i;
        end
      end
      S_FEED: begin
        if (cnt_q == last_feed) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == FL_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DR_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they can be registered
  // while still lining up with the cycle that state is in.
  always_comb begin
    klen_d = {1'b0, k_d};
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    ov_d   = (state_d == S_DRAIN);
    clr_d  = (state_d == S_FEED) && (cnt_d == '0);
    fcnt_d = (state_d == S_FEED) ? cnt_d : '0;
    orow_d = (state_d == S_DRAIN) ? cnt_d[RW-1:0] : '0;
    row_d  = '0;
    col_d  = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_d[r] = (state_d == S_FEED)
               && (cnt_d >= CW'(r))
               && (cnt_d < CW'(r) + klen_d);
    end
    for (int c = 0; c < COLS; c++) begin
      col_d[c] = (state_d == S_FEED)
               && (cnt_d >= CW'(c))
               && (cnt_d < CW'(c) + klen_d);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      mode_q      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      clr_o       <= 1'b0;
      feed_cnt_o  <= '0;
      row_en_o    <= '0;
      col_en_o    <= '0;
      out_valid_o <= 1'b0;
      out_row_o   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      clr_o       <= clr_d;
      feed_cnt_o  <= fcnt_d;
      row_en_o    <= row_d;
      col_en_o    <= col_d;
      out_valid_o <= ov_d;
      out_row_o   <= orow_d;
    end
  end

  assign mode_o = mode_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomised scoreboard bench for systolic_seq_ctrl.
// Expected outputs come from a cycle-indexed job model.
module tb_systolic_seq_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KW     = 8;
  localparam int PE_LAT = 2;
  localparam int MAXD   = (ROWS > COLS) ? ROWS : COLS;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  mode;
    logic        clr;
    logic [KW:0] fcnt;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        ov;
    logic [1:0]  orow;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [KW-1:0] k_len_i = '0;
  logic [1:0]    mode_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, clr_o, out_valid_o;
  logic [1:0]    mode_o;
  logic [KW:0]   feed_cnt_o;
  logic [3:0]    row_en_o, col_en_o;
  logic [1:0]    out_row_o;

  systolic_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .K_WIDTH(KW), .PE_LAT(PE_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .k_len_i(k_len_i),
    .mode_i(mode_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .mode_o(mode_o), .clr_o(clr_o), .feed_cnt_o(feed_cnt_o),
    .row_en_o(row_en_o), .col_en_o(col_en_o),
    .out_valid_o(out_valid_o), .out_row_o(out_row_o)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit         m_act = 0;
  int         m_j = 0;
  int         m_k = 0;
  logic [1:0] m_mode = '0;

  function automatic out_t cur();
    return {busy_o, done_o, mode_o, clr_o, feed_cnt_o,
            row_en_o, col_en_o, out_valid_o, out_row_o};
  endfunction

  function automatic int n_feed(int k);
    return k + MAXD - 1;
  endfunction

  localparam int N_FLUSH = COLS - 1 + PE_LAT + 1;

  function automatic int total_cyc(int k);
    return n_feed(k) + N_FLUSH + ROWS + 1;
  endfunction

  // Output expected in cycle j (1-based) of a job with length k.
  function automatic out_t ref_out(bit act, int j, int k, logic [1:0] m);
    out_t o;
    int   f, t;
    o = '0;
    o.mode = m;
    if (!act) return o;
    o.busy = 1'b1;
    f = n_feed(k);
    if (j <= f) begin
      t = j - 1;
      o.fcnt = t[KW:0];
      o.clr = (t == 0);
      for (int r = 0; r < ROWS; r++) o.row[r] = (t >= r) && (t < r + k);
      for (int c = 0; c < COLS; c++) o.col[c] = (t >= c) && (t < c + k);
    end else if (j <= f + N_FLUSH) begin
      o.busy = 1'b1;
    end else if (j <= f + N_FLUSH + ROWS) begin
      o.ov = 1'b1;
      t = j - f - N_FLUSH - 1;
      o.orow = t[1:0];
    end else begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = cur();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t got %h exp %h (job j=%0d k=%0d)",
                 $time, a, e, m_j, m_k);
      end
    end
  end

  task automatic chk_zero(input string name);
    checks++;
    if (cur() !== '0) begin
      errors++;
      $display("FAIL %s got %h exp 0", name, cur());
    end
  endtask

  // One clock: apply inputs, advance the model across the edge, queue
  // the expected output for the cycle that follows.
  task automatic step(input bit st, input int k, input logic [1:0] md,
                      input bit ab);
    start_i = st;
    k_len_i = k[KW-1:0];
    mode_i  = md;
    abort_i = ab;
    if (rst) begin
      m_act  = 0;
      m_mode = '0;
    end else if (m_act) begin
      if (ab || m_j == total_cyc(m_k)) m_act = 0;
      else m_j++;
    end else if (st && k != 0) begin
      m_act  = 1;
      m_j    = 1;
      m_k    = k;
      m_mode = md;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(ref_out(m_act, m_j, m_k, m_mode));
    start_i = 0;
    abort_i = 0;
  endtask

  task automatic run_idle();
    while (m_act) step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
  endtask

  initial begin
    int k;
    #1;
    chk_zero("reset_state");
    repeat (3) step(0, 0, 2'b00, 0);
    rst = 0;

    step(1, 3, 2'b00, 0);
    run_idle();

    step(1, 1, 2'b01, 0);
    run_idle();

    step(1, 0, 2'b10, 0);
    repeat (4) step(0, 0, 2'b00, 0);

    step(1, 2, 2'b00, 0);
    while (m_j < n_feed(2) + N_FLUSH + 1) step(0, 0, 2'b00, 0);
    step(1, 5, 2'b10, 0);
    step(1, 5, 2'b10, 0);
    run_idle();

    step(1, 4, 2'b01, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 1);
    step(1, 2, 2'b11, 0);
    run_idle();

    step(1, 2, 2'b10, 0);
    while (m_j < n_feed(2) + 2) step(0, 0, 2'b00, 0);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk_zero("reset_mid_flush");
    m_act  = 0;
    m_mode = '0;
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    rst = 0;
    step(1, 2, 2'b01, 0);
    run_idle();

    step(1, 255, 2'b00, 0);
    run_idle();

    for (int n = 0; n < 40; n++) begin
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      step(1, k, 2'($urandom_range(0, 3)), 0);
      while (m_act) begin
        step($urandom_range(0, 6) == 0, int'($urandom_range(0, 20)),
             2'($urandom_range(0, 3)), $urandom_range(0, 60) == 0);
      end
      repeat ($urandom_range(0, 3)) step(0, 0, 2'b00, 0);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for a ROWS x COLS systolic array of MAC/maxpool processing elements.
- Accepts a job command carrying the reduction length K and the mode.
- Generates the skewed operand-feed enables, the array clear pulse and the mode, then waits out the array pipeline and drains result rows to the writeback path.
- Sits between the command/control unit and the operand/result buffers of the array.

Parameters:
- ROWS, 4, array rows; one skewed A-operand lane per row.
- COLS, 4, array columns; one skewed B-operand lane per column.
- K_WIDTH, 8, width of the reduction-length field and of the feed counter.
- PE_LAT, 2, cycles from PE operand input to PE psum output.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  job request; sampled only in IDLE.
- k_len_i  in  K_WIDTH  reduction length K; valid with start_i.
- mode_i  in  2  00 = conv, 01 = maxpool; valid with start_i.
- abort_i  in  1  synchronous job abort.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  single-cycle job-complete pulse.
- mode_o  out  2  latched mode, driven to every PE.
- clr_o  out  1  accumulator clear, driven into the array origin PE.
- feed_cnt_o  out  K_WIDTH+1  feed cycle index t.
- row_en_o  out  ROWS  bit r = A lane r presents element (t-r) this cycle; the lane drives zero when its bit is low.
- col_en_o  out  COLS  bit c = B lane c presents element (t-c) this cycle; the lane drives zero when its bit is low.
- out_valid_o  out  1  result row available on the array psum outputs.
- out_row_o  out  clog2(ROWS)  index of the row being written back.

Behaviour:
- Reset (rst_i high, any time, including mid-job): state IDLE.
  - All outputs 0: busy_o, done_o, mode_o, clr_o, feed_cnt_o, row_en_o, col_en_o, out_valid_o, out_row_o.
  - Latched K and mode cleared.
- FSM states: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - start_i=1 with k_len_i!=0 at a rising edge latches K and mode and moves to FEED.
  - start_i with k_len_i==0 is ignored: stay IDLE, no done_o.
  - start_i is ignored in every other state; there is no queueing.
- FEED: lasts F = K + max(ROWS,COLS) - 1 cycles; t counts 0..F-1.
  - row_en_o[r] = (t >= r) && (t < r+K).
  - col_en_o[c] = (t >= c) && (t < c+K).
  - clr_o = 1 only at t==0, so it travels diagonally with the first operand.
  - Exits to FLUSH after t==F-1.
- FLUSH: counts FL = COLS - 1 + PE_LAT + 1 cycles with every enable at 0; then moves to DRAIN.
- DRAIN: ROWS cycles.
  - out_valid_o=1 throughout.
  - out_row_o counts 0..ROWS-1, one per cycle.
  - Then moves to DONE.
- DONE: one cycle with done_o=1, then back to IDLE.
- mode_o: holds the latched mode from the start edge until the next accepted start. It never changes mid-job.
- feed_cnt_o is 0 outside FEED.
- abort_i=1 in any non-IDLE state: at the next edge go to IDLE with all enables, clr_o and out_valid_o at 0. No done_o is produced. abort_i has priority over every other transition.
- Width and range rules:
  - The feed counter is K_WIDTH+1 bits, so F up to 2^K_WIDTH - 1 + max(ROWS,COLS) - 1 cannot wrap.
  - Enable comparisons are unsigned against the extended width.
  - K = 2^K_WIDTH - 1 is legal.
- All outputs are registered: each output reflects the current state and counter values, with no combinational path from inputs to outputs.

Test Plan:
- ROWS=COLS=4, K=3, start at edge 0:
  - FEED cycles 1..6 with t=0..5; row_en_o = 0001, 0011, 0111, 1110, 1100, 1000.
  - clr_o only in cycle 1.
  - FLUSH cycles 7..12.
  - DRAIN cycles 13..16 with out_row_o = 0, 1, 2, 3.
  - done_o in cycle 17; busy_o high in cycles 1..17.
- K=1, mode_i=01: mode_o=01 from cycle 1 to the end of the job; row_en_o is one-hot walking 0001 -> 1000 over 4 cycles; done_o at cycle 15.
- start_i with k_len_i=0 -> busy_o stays 0 and done_o never asserts. start_i re-pulsed during DRAIN -> ignored, exactly one done_o.
- abort_i asserted at FEED t=2 -> next cycle IDLE, row_en_o=0, no done_o. A new start is accepted on the following edge.
- rst_i asserted asynchronously mid-FLUSH (between edges) -> all outputs 0 immediately. After release, a K=2 job completes normally.
- K=255, K_WIDTH=8 -> F=258 feed cycles, feed_cnt_o reaches 257 without wrap, row_en_o[3] deasserts at t=258.
